// File: rtl/input_conditioner.sv
// Per-channel input conditioning: synchroniser chain, stability-counter debounce,
// registered rise/fall pulses and a press-toggle latch.
module input_conditioner #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] toggle_out
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_ff;
    logic [CW-1:0]          cnt;
    logic                   clean;
    logic                   rise;
    logic                   fall;
    logic                   tog;
    logic                   sync_q;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sync_ff <= '0;
        cnt     <= '0;
        clean   <= 1'b0;
        rise    <= 1'b0;
        fall    <= 1'b0;
        tog     <= 1'b0;
      end else begin
        sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw_in[g]};
        rise    <= 1'b0;
        fall    <= 1'b0;
        if (sync_q == clean) begin
          cnt <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end else begin
          // Accept the new level; the pulse lands in the same cycle clean flips.
          clean <= sync_q;
          cnt   <= '0;
          rise  <= sync_q;
          fall  <= ~sync_q;
          tog   <= tog ^ sync_q;
        end
      end
    end

    assign clean_out[g]  = clean;
    assign rise_pulse[g] = rise;
    assign fall_pulse[g] = fall;
    assign toggle_out[g] = tog;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random
// stimulus against a sliding-window reference model of the debounce rule.
module tb_input_conditioner;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int D  = 16;
  localparam int MAXC = 8192;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] raw_in;
  logic [N-1:0] clean_out, rise_pulse, fall_pulse, toggle_out;

  input_conditioner #(
    .N_CH(N),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_in(raw_in),
    .clean_out(clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_out(toggle_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: raw samples per edge, the synchronised value seen before
  // each edge, and a level flips once D consecutive post-reset samples differ.
  logic [N-1:0] rq [0:MAXC-1];
  logic [N-1:0] sp [0:MAXC-1];
  int           cyc = 0;
  int           last_rst = 0;
  logic [N-1:0] m_clean = '0, m_rise = '0, m_fall = '0, m_tog = '0;

  int           rise_cnt [N];
  int           fall_cnt [N];
  logic [2:0]   seq3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic rn);
    logic stable;
    cyc++;
    if (!rn) begin
      last_rst = cyc;
      rq[cyc]  = '0;
      sp[cyc]  = '0;
      m_clean  = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_tog    = '0;
      return;
    end
    rq[cyc] = r;
    sp[cyc] = (cyc - S > last_rst) ? rq[cyc-S] : '0;
    m_rise  = '0;
    m_fall  = '0;
    for (int ch = 0; ch < N; ch++) begin
      stable = 1'b1;
      for (int i = cyc - D + 1; i <= cyc; i++)
        if (i <= last_rst || sp[i][ch] == m_clean[ch]) stable = 1'b0;
      if (stable) begin
        m_clean[ch] = ~m_clean[ch];
        if (m_clean[ch]) begin
          m_rise[ch] = 1'b1;
          m_tog[ch]  = ~m_tog[ch];
        end else begin
          m_fall[ch] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick(input logic [N-1:0] r, input logic rn);
    raw_in  = r;
    reset_n = rn;
    @(posedge clk);
    model_edge(r, rn);
    #1;
    check("clean_out", 32'(clean_out), 32'(m_clean));
    check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    check("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    check("toggle_out", 32'(toggle_out), 32'(m_tog));
    for (int ch = 0; ch < N; ch++) begin
      rise_cnt[ch] += int'(rise_pulse[ch]);
      fall_cnt[ch] += int'(fall_pulse[ch]);
    end
    if (rise_pulse[3]) seq3 = {seq3[1:0], toggle_out[3]};
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < N; ch++) begin
      rise_cnt[ch] = 0;
      fall_cnt[ch] = 0;
    end
    seq3 = '0;
  endtask

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, t0, t3;
    logic [N-1:0] r;
    logic [N-1:0] cur;
    int hold [N];
    logic [5:0] bounce;

    raw_in  = '0;
    reset_n = 1'b0;
    clear_counts();

    // Reset with inputs high: nothing may leak out.
    for (int i = 0; i < 3; i++) tick(4'b1111, 1'b0);
    check("rst_outputs", 32'({clean_out, rise_pulse, fall_pulse, toggle_out}), 32'h0);

    // Step on channel 0 and measure latency.
    n = 0;
    do begin tick(4'b0001, 1'b1); n++; end while (!clean_out[0] && n < 40);
    check("lat_ch0", 32'(n), 32'd18);
    check("rise_ch0_at_accept", 32'(rise_pulse), 32'h1);
    check("tog_ch0", 32'(toggle_out), 32'h1);
    tick(4'b0001, 1'b1);
    check("rise_ch0_one_cycle", 32'(rise_pulse), 32'h0);

    // 10-cycle glitch on channel 1.
    clear_counts();
    for (int i = 0; i < 10; i++) tick(4'b0011, 1'b1);
    for (int i = 0; i < 30; i++) tick(4'b0001, 1'b1);
    check("glitch_ch1_rises", 32'(rise_cnt[1]), 32'd0);
    check("glitch_ch1_levels", 32'({clean_out[1], toggle_out[1]}), 32'd0);

    // Bounce 1,0,1,1,0 then stable 1 on channel 2.
    clear_counts();
    bounce = 6'b101101;
    for (int i = 0; i < 5; i++) tick({1'b0, bounce[5-i], 2'b01}, 1'b1);
    n = 0;
    do begin tick(4'b0101, 1'b1); n++; end while (!clean_out[2] && n < 40);
    check("lat_ch2_bounce", 32'(n), 32'd18);
    for (int i = 0; i < 5; i++) tick(4'b0101, 1'b1);
    check("rise_ch2_single", 32'(rise_cnt[2]), 32'd1);
    for (int i = 0; i < 25; i++) tick(4'b0001, 1'b1);
    check("fall_ch2_single", 32'(fall_cnt[2]), 32'd1);
    check("tog_ch2_kept", 32'(toggle_out[2]), 32'd1);

    // Three press/release cycles on channel 3.
    clear_counts();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 25; i++) tick(4'b1001, 1'b1);
      for (int i = 0; i < 25; i++) tick(4'b0001, 1'b1);
    end
    check("ch3_rises", 32'(rise_cnt[3]), 32'd3);
    check("ch3_falls", 32'(fall_cnt[3]), 32'd3);
    check("ch3_toggle_seq", 32'(seq3), 32'b101);

    // Reset mid-count, then re-qualification from scratch.
    for (int i = 0; i < 2; i++) tick(4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) tick(4'b1111, 1'b1);
    tick(4'b1111, 1'b0);
    check("midrst_outputs", 32'({clean_out, rise_pulse, fall_pulse, toggle_out}), 32'h0);
    n = 0;
    do begin tick(4'b1111, 1'b1); n++; end while (rise_pulse == '0 && n < 40);
    check("midrst_lat", 32'(n), 32'd18);
    check("midrst_rise", 32'(rise_pulse), 32'hF);

    // Channels 0 and 3 stepped 5 cycles apart.
    for (int i = 0; i < 2; i++) tick(4'b0000, 1'b0);
    t0 = -1;
    t3 = -1;
    for (int t = 1; t <= 40; t++) begin
      tick((t >= 6) ? 4'b1001 : 4'b0001, 1'b1);
      if (rise_pulse[0] && t0 < 0) t0 = t;
      if (rise_pulse[3] && t3 < 0) t3 = t;
    end
    check("indep_t0", 32'(t0), 32'd18);
    check("indep_gap", 32'(t3 - t0), 32'd5);

    // Random holds of varying length with occasional resets.
    cur = '0;
    for (int ch = 0; ch < N; ch++) hold[ch] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (hold[ch] == 0) begin
          cur[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(1, 5))
                                                   : int'($urandom_range(10, 40));
        end
        hold[ch]--;
      end
      r = cur;
      tick(r, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions raw board switch/button inputs before they reach the LED logic.
- Per channel, it synchronises the asynchronous pin into the clock domain and debounces it with a stability counter.
- It produces a clean level, single-cycle rise/fall pulses and a per-channel toggle state.
- On Zybo Z7-20 it sits directly upstream of the LED drive stage; the sw and btn inputs of that stage take clean_out, or toggle_out for latched buttons.

Parameters:
- N_CH, 4, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flop depth; legal values 2..4.
- DEBOUNCE_CYCLES, 1250000, consecutive cycles a synchronised value must hold before it is accepted (10 ms at 125 MHz); legal values >= 2.

Ports:
- clk  input  1  system clock, 125 MHz on board.
- reset_n  input  1  synchronous active-low reset.
- raw_in  input  N_CH  asynchronous pin levels (switches/buttons, active-high).
- clean_out  output  N_CH  debounced level.
- rise_pulse  output  N_CH  one-cycle pulse when clean_out goes 0->1.
- fall_pulse  output  N_CH  one-cycle pulse when clean_out goes 1->0.
- toggle_out  output  N_CH  inverts on every rise_pulse of its channel.

Behaviour:
- Clock and reset: single clock domain; reset_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: while reset_n=0 at an edge, all of the following clear to 0: synchroniser flops, debounce counters, clean_out, rise_pulse, fall_pulse, toggle_out. No pulses are generated out of reset, even if raw_in=1.
- Channel independence: all channels are fully independent; there is no cross-channel interaction.
- Synchroniser: SYNC_STAGES-deep flop chain per channel; sync_q denotes the last stage. No logic between stages.
- Debounce counter: width = clog2(DEBOUNCE_CYCLES). Per channel, each cycle:
  - sync_q == clean_out: counter <= 0.
  - sync_q != clean_out and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync_q != clean_out and counter == DEBOUNCE_CYCLES-1: clean_out <= sync_q, counter <= 0, fire the corresponding edge pulse.
- Glitch rejection: any return of sync_q to clean_out before acceptance resets the counter. A glitch shorter than DEBOUNCE_CYCLES cycles never changes clean_out.
- Latency: raw_in stepped and held from cycle 0 (sampled at edge 1) -> clean_out changes after edge SYNC_STAGES+DEBOUNCE_CYCLES. That is 18 edges at defaults of SYNC_STAGES=2, DEBOUNCE_CYCLES=16.
- Pulses: registered. rise_pulse/fall_pulse are high for exactly the one cycle in which clean_out first shows the new value, then return to 0.
  - rise and fall of the same channel are never high together.
  - Minimum spacing between pulses of one channel is DEBOUNCE_CYCLES cycles.
- Toggle: toggle_out flips on the same edge that sets rise_pulse, so the new toggle value and the pulse appear in the same cycle. Fall events do not affect it.
- Continuous bounce: if raw_in alternates every cycle forever, clean_out holds and no pulses occur.
- Reset mid-operation: asserting reset_n while a counter is mid-count aborts the count; outputs return to 0 on that edge. After release, an input held at 1 is re-qualified from scratch: rise_pulse fires SYNC_STAGES+DEBOUNCE_CYCLES cycles after release.
- Counter range: the counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Test Plan (DEBOUNCE_CYCLES=16, SYNC_STAGES=2, N_CH=4 in simulation):
- Reset, then raw_in=4'b0001 held -> clean_out[0]=1 exactly 18 edges after the first sampling edge; rise_pulse[0] high for 1 cycle at that cycle; toggle_out[0]=1; other channels stay 0.
- raw_in[1] pulsed high for 10 cycles (shorter than 16) -> clean_out[1], rise_pulse[1] and toggle_out[1] remain 0 throughout.
- raw_in[2] bounce pattern 1,0,1,1,0,1 then stable 1 -> clean_out[2] rises 18 cycles after the last 0->1 transition, with a single rise_pulse[2]; the later 1->0 step held gives fall_pulse[2] once and toggle_out[2] unchanged.
- Three debounced press/release cycles on channel 3 -> toggle_out[3] sequence 1,0,1; three rise_pulse and three fall_pulse, each one cycle wide.
- raw_in=4'b1111 held, reset_n pulsed low at count 10 of 16 -> all outputs 0 on the reset edge; rise_pulse=4'b1111 on the same cycle, 18 cycles after reset release.
- Independent timing across channels: channels 0 and 3 stepped high 5 cycles apart -> their pulses are also 5 cycles apart, with no interaction between channels.
